polar_sequencer: RTL and testbench

Drives the polarization-channel illumination sequence: steps through NCH channels, asserts one LED/shutter select at a time, and for each channel runs the dwell timer through its start/setcount/timeout interface. The dwell timer counts while start is high, pulses timeout for one cycle on reaching setcount, then recounts from 0. Sits between the host configuration registers and the timer/illumination drivers.

---
 rtl/polar_seq_pkg.sv | 7 +
 rtl/polar_dwell_regs.sv | 26 ++
 rtl/polar_sequencer.sv | 101 ++++++++++
 tb/tb_polar_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/polar_seq_pkg.sv
// polar_seq_pkg: shared state encoding and default sizing for the polarization sequencer
package polar_seq_pkg;
  localparam int NCH_DEF = 4;
  localparam int CW_DEF = 2;
  localparam int TW_DEF = 16;
  typedef enum logic [1:0] {IDLE, LOAD, DWELL} state_t;
endpackage

// File: rtl/polar_dwell_regs.sv
// polar_dwell_regs: per-channel dwell registers with zero clamp and combinational read port
module polar_dwell_regs
  import polar_seq_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW = CW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [CW-1:0] i_waddr,
  input  logic [TW-1:0] i_wdata,
  input  logic [CW-1:0] i_raddr,
  output logic [TW-1:0] o_rdata
);
  logic [TW-1:0] r_dwell [NCH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_dwell[i] <= TW'(1);
    end else if (i_we) begin
      r_dwell[i_waddr] <= (i_wdata == '0) ? TW'(1) : i_wdata;
    end
  end
  assign o_rdata = r_dwell[i_raddr];
endmodule

// File: rtl/polar_sequencer.sv
// polar_sequencer: steps through polarization channels, one LED at a time,
// running the external dwell timer for each channel.
module polar_sequencer
  import polar_seq_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW = CW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic           stop,
  input  logic           loop,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_addr,
  input  logic [TW-1:0]  cfg_dwell,
  input  logic           tmr_timeout,
  output logic           tmr_start,
  output logic [TW-1:0]  tmr_setcount,
  output logic [NCH-1:0] led_sel,
  output logic [CW-1:0]  chan_idx,
  output logic           busy,
  output logic           frame_done,
  output logic [15:0]    frame_cnt
);
  state_t r_state, w_next;
  logic [CW-1:0] r_ch, w_ch;
  logic [TW-1:0] r_set, w_dwell;
  logic [NCH-1:0] r_led;
  logic [15:0] r_fcnt;
  logic r_start, r_busy, r_done, r_first, w_done, w_last;

  polar_dwell_regs #(.NCH(NCH), .CW(CW), .TW(TW)) u_regs (
    .clk    (clk),
    .rst    (rst),
    .i_we   (cfg_we),
    .i_waddr(cfg_addr),
    .i_wdata(cfg_dwell),
    .i_raddr(r_ch),
    .o_rdata(w_dwell)
  );

  assign w_last = r_ch == CW'(NCH - 1);

  always_comb begin
    w_next = r_state;
    w_ch = r_ch;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = (go && !stop) ? LOAD : IDLE;
        w_ch = (go && !stop) ? '0 : r_ch;
      end
      LOAD: w_next = stop ? IDLE : DWELL;
      DWELL: begin
        // the first DWELL cycle masks timeouts left over from before the timer was restarted
        if (stop) begin
          w_next = IDLE;
        end else if (tmr_timeout && !r_first) begin
          w_done = w_last;
          w_next = (!w_last || loop) ? LOAD : IDLE;
          w_ch = !w_last ? r_ch + 1'b1 : (loop ? '0 : r_ch);
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch <= '0;
      r_set <= TW'(1);
      r_led <= '0;
      r_start <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_first <= 1'b0;
      r_fcnt <= '0;
    end else begin
      r_state <= w_next;
      r_ch <= w_ch;
      r_set <= (r_state == LOAD) ? w_dwell : r_set;
      r_led <= (w_next == DWELL) ? {{(NCH-1){1'b0}}, 1'b1} << r_ch : '0;
      r_start <= w_next == DWELL;
      r_busy <= w_next != IDLE;
      r_done <= w_done;
      r_first <= r_state == LOAD;
      r_fcnt <= r_fcnt + 16'(w_done);
    end
  end

  assign tmr_start = r_start;
  assign tmr_setcount = r_set;
  assign led_sel = r_led;
  assign chan_idx = r_ch;
  assign busy = r_busy;
  assign frame_done = r_done;
  assign frame_cnt = r_fcnt;
endmodule

// File: tb/tb_polar_sequencer.sv
// tb_polar_sequencer: directed and random stimulus against a cycle-budget reference model
module tb_polar_sequencer;
  localparam int NCH = 4;
  localparam int CW = 2;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst, go, stop, loop, cfg_we, tmr_timeout, inj;
  logic [CW-1:0] cfg_addr;
  logic [TW-1:0] cfg_dwell;
  logic tmr_start, busy, frame_done;
  logic [TW-1:0] tmr_setcount;
  logic [NCH-1:0] led_sel;
  logic [CW-1:0] chan_idx;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  polar_sequencer #(.NCH(NCH), .CW(CW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .go(go), .stop(stop), .loop(loop),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dwell(cfg_dwell),
    .tmr_timeout(tmr_timeout), .tmr_start(tmr_start), .tmr_setcount(tmr_setcount),
    .led_sel(led_sel), .chan_idx(chan_idx), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  // environment dwell timer: counts while start is high, one-cycle timeout on reaching setcount
  logic [TW-1:0] t_cnt = '0;
  logic t_to = 1'b0;
  always @(posedge clk) begin
    if (!tmr_start) begin
      t_cnt <= '0;
      t_to <= 1'b0;
    end else if (t_cnt == tmr_setcount) begin
      t_cnt <= '0;
      t_to <= 1'b1;
    end else begin
      t_cnt <= t_cnt + 1'b1;
      t_to <= 1'b0;
    end
  end
  assign tmr_timeout = t_to | inj;

  // reference model: each channel is 1 dark LOAD cycle then dwell+2 lit cycles
  bit m_busy, m_load, m_done;
  int m_ch, m_left, m_set, m_fcnt;
  int m_dw[NCH];

  int errors = 0, checks = 0, cyc = 0, ndone = 0;
  int hi[NCH];
  int dcyc[$];

  function automatic void m_reset();
    m_busy = 0; m_load = 0; m_done = 0;
    m_ch = 0; m_left = 0; m_set = 1; m_fcnt = 0;
    for (int k = 0; k < NCH; k++) m_dw[k] = 1;
  endfunction

  function automatic bit m_on();
    return m_busy && !m_load;
  endfunction

  function automatic void m_step();
    if (rst) begin
      m_reset();
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      if (go && !stop) begin
        m_busy = 1; m_load = 1; m_ch = 0;
      end
    end else begin
      if (m_load) m_set = m_dw[m_ch];
      if (stop) begin
        m_busy = 0; m_load = 0;
      end else if (m_load) begin
        m_load = 0; m_left = m_set + 2;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_ch < NCH - 1) begin
            m_ch++; m_load = 1;
          end else begin
            m_done = 1;
            m_fcnt = (m_fcnt + 1) % 65536;
            if (loop) begin
              m_ch = 0; m_load = 1;
            end else m_busy = 0;
          end
        end
      end
    end
    if (cfg_we) m_dw[cfg_addr] = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    m_step();
    @(negedge clk);
    cyc++;
    chk("tmr_start", 32'(tmr_start), 32'(m_on()));
    chk("tmr_setcount", 32'(tmr_setcount), 32'(m_set));
    chk("led_sel", 32'(led_sel), m_on() ? 32'(1) << m_ch : 32'(0));
    chk("chan_idx", 32'(chan_idx), 32'(m_ch));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    for (int k = 0; k < NCH; k++) if (led_sel == NCH'(1) << k) hi[k]++;
    if (frame_done) begin
      ndone++;
      dcyc.push_back(cyc);
    end
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1; cfg_addr = CW'(a); cfg_dwell = TW'(d);
    tick();
    cfg_we = 0;
  endtask

  task automatic pulse_rst();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic start_frame();
    go = 1; tick(); go = 0;
  endtask

  task automatic clr_hi();
    for (int k = 0; k < NCH; k++) hi[k] = 0;
  endtask

  initial begin
    int f;
    m_reset();
    rst = 1; go = 0; stop = 0; loop = 0; cfg_we = 0; cfg_addr = '0; cfg_dwell = '0; inj = 0;
    repeat (3) tick();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      inj = (i % 3 == 0);
      tick();
    end
    inj = 0;
    chk("idle_busy", 32'(busy), 0);

    wr(0, 3); wr(1, 5); wr(2, 1); wr(3, 2);
    clr_hi(); ndone = 0; loop = 0;
    start_frame();
    for (int n = 0; n < 200 && m_busy; n++) tick();
    chk("single_idle", 32'(busy), 0);
    chk("single_hi0", hi[0], 5);
    chk("single_hi1", hi[1], 7);
    chk("single_hi2", hi[2], 3);
    chk("single_hi3", hi[3], 4);
    chk("single_ndone", ndone, 1);
    chk("single_fcnt", 32'(frame_cnt), 1);

    pulse_rst();
    for (int k = 0; k < NCH; k++) wr(k, 4);
    loop = 1; ndone = 0; dcyc.delete();
    start_frame();
    for (int n = 0; n < 200 && ndone < 2; n++) tick();
    loop = 0;
    for (int n = 0; n < 100 && m_busy; n++) tick();
    chk("loop_ndone", ndone, 3);
    if (dcyc.size() == 3) begin
      chk("loop_period1", dcyc[1] - dcyc[0], 28);
      chk("loop_period2", dcyc[2] - dcyc[1], 28);
    end
    chk("loop_fcnt", 32'(frame_cnt), 3);
    chk("loop_idle", 32'(busy), 0);

    pulse_rst();
    wr(0, 2); wr(1, 0); wr(2, 3); wr(3, 2);
    loop = 1; ndone = 0; clr_hi();
    start_frame();
    for (int n = 0; n < 50 && !(m_on() && m_ch == 1); n++) tick();
    chk("zero_clamp_set", 32'(tmr_setcount), 1);
    for (int n = 0; n < 50 && !(m_on() && m_ch == 2); n++) tick();
    chk("reach_ch2", 32'(led_sel), 32'b0100);
    wr(2, 10);
    chk("live_keep", 32'(tmr_setcount), 3);
    for (int n = 0; n < 100 && ndone == 0; n++) tick();
    chk("f1_hi1", hi[1], 3);
    chk("f1_hi2", hi[2], 5);
    loop = 0; clr_hi();
    for (int n = 0; n < 100 && m_busy; n++) tick();
    chk("f2_hi1", hi[1], 3);
    chk("f2_hi2", hi[2], 12);

    pulse_rst();
    wr(0, 2); wr(1, 2); wr(2, 6); wr(3, 2);
    ndone = 0;
    start_frame();
    for (int n = 0; n < 100 && !(m_on() && m_ch == 2 && m_left == 4); n++) tick();
    f = int'(frame_cnt);
    stop = 1; tick(); stop = 0;
    chk("abort_led", 32'(led_sel), 0);
    chk("abort_start", 32'(tmr_start), 0);
    chk("abort_done", 32'(frame_done), 0);
    chk("abort_fcnt", 32'(frame_cnt), 32'(f));
    repeat (3) tick();
    start_frame();
    for (int n = 0; n < 100 && !(m_on() && m_ch == NCH - 1 && t_to); n++) tick();
    chk("stop_to_seen", 32'(t_to), 1);
    stop = 1; tick(); stop = 0;
    chk("stop_to_busy", 32'(busy), 0);
    chk("stop_to_done", 32'(frame_done), 0);
    chk("stop_to_fcnt", 32'(frame_cnt), 32'(f));
    repeat (3) tick();
    chk("abort_ndone", ndone, 0);

    start_frame();
    for (int n = 0; n < 100 && !(m_load && m_ch == 3); n++) tick();
    pulse_rst();
    chk("rst_led", 32'(led_sel), 0);
    chk("rst_start", 32'(tmr_start), 0);
    chk("rst_set", 32'(tmr_setcount), 1);
    chk("rst_idx", 32'(chan_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);
    start_frame();
    tick();
    chk("restart_led", 32'(led_sel), 1);
    chk("restart_idx", 32'(chan_idx), 0);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      go = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) loop = ~loop;
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_addr = CW'($urandom_range(0, NCH - 1));
      cfg_dwell = TW'($urandom_range(0, 6));
      inj = (!m_busy || m_load || (m_on() && m_left == m_set + 2)) && ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 0; go = 0; stop = 0; cfg_we = 0; inj = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
